// File: rtl/regfile_writeback_queue_if.sv
// Producer/consumer bundle for the write-back queue: two result lanes in,
// two register-file write ports out, plus occupancy status.
interface regfile_writeback_queue_if #(parameter int DEPTH = 8);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          InValid1, InValid2;
  logic [4:0]    InReg1, InReg2;
  logic [31:0]   InData1, InData2;
  logic          InReady;
  logic          OutEnable;
  logic          RegWrite1, RegWrite2;
  logic [4:0]    WriteRegister1, WriteRegister2;
  logic [31:0]   WriteData1, WriteData2;
  logic [CW-1:0] Count;
  logic          Empty, Full;
  logic [7:0]    CollisionCount;

  modport master (
    output InValid1, InReg1, InData1, InValid2, InReg2, InData2, OutEnable,
    input  InReady, RegWrite1, WriteRegister1, WriteData1,
           RegWrite2, WriteRegister2, WriteData2, Count, Empty, Full, CollisionCount
  );

  modport slave (
    input  InValid1, InReg1, InData1, InValid2, InReg2, InData2, OutEnable,
    output InReady, RegWrite1, WriteRegister1, WriteData1,
           RegWrite2, WriteRegister2, WriteData2, Count, Empty, Full, CollisionCount
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// Dual-in / dual-out write-back FIFO feeding a two-write-port register file;
// same-register pairs popped together collapse onto port 2 (younger wins).
module regfile_writeback_queue #(
  parameter int DEPTH     = 8,
  parameter bit DROP_ZERO = 1'b1
) (
  input logic                   Clk,
  input logic                   Rst,
  regfile_writeback_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t           mem_q [DEPTH];
  wb_t           mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic [7:0]    coll_q, coll_d;
  logic          rw1_q, rw1_d, rw2_q, rw2_d;
  wb_t           p1_q, p1_d, p2_q, p2_d;

  logic [1:0]    npop;
  logic          keep1, keep2;
  wb_t           e0, e1;

  always_comb begin
    mem_d      = mem_q;
    e0         = mem_q[rd_ptr_q];
    e1         = mem_q[rd_ptr_q + PW'(1)];
    p1_d       = p1_q;
    p2_d       = p2_q;
    rw1_d      = 1'b0;
    rw2_d      = 1'b0;
    coll_d     = coll_q;

    // Pop count uses the pre-push occupancy, so same-cycle pushes never drain.
    if (!bus.OutEnable)           npop = 2'd0;
    else if (count_q >= CW'(2))   npop = 2'd2;
    else                          npop = count_q[1:0];

    if (npop == 2'd2) begin
      rw2_d = 1'b1;
      p2_d  = e1;
      if (e0.rd == e1.rd) begin
        if (coll_q != 8'hFF) coll_d = coll_q + 8'd1;
      end else begin
        rw1_d = 1'b1;
        p1_d  = e0;
      end
    end else if (npop == 2'd1) begin
      rw1_d = 1'b1;
      p1_d  = e0;
    end

    keep1 = in_ready_q && bus.InValid1 && !(DROP_ZERO && bus.InReg1 == 5'd0);
    keep2 = in_ready_q && bus.InValid2 && !(DROP_ZERO && bus.InReg2 == 5'd0);
    if (keep1) mem_d[wr_ptr_q] = '{rd: bus.InReg1, data: bus.InData1};
    if (keep2) mem_d[wr_ptr_q + PW'(keep1)] = '{rd: bus.InReg2, data: bus.InData2};

    rd_ptr_d   = rd_ptr_q + PW'(npop);
    wr_ptr_d   = wr_ptr_q + PW'(keep1) + PW'(keep2);
    count_d    = count_q + CW'(keep1) + CW'(keep2) - CW'(npop);
    in_ready_d = (CW'(DEPTH) - count_d) >= CW'(2);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      coll_q     <= '0;
      rw1_q      <= 1'b0;
      rw2_q      <= 1'b0;
      p1_q       <= '0;
      p2_q       <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      coll_q     <= coll_d;
      rw1_q      <= rw1_d;
      rw2_q      <= rw2_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
    end
  end

  // Storage needs no reset: pointers and count gate every read.
  always_ff @(posedge Clk) mem_q <= mem_d;

  assign bus.InReady        = in_ready_q;
  assign bus.RegWrite1      = rw1_q;
  assign bus.WriteRegister1 = p1_q.rd;
  assign bus.WriteData1     = p1_q.data;
  assign bus.RegWrite2      = rw2_q;
  assign bus.WriteRegister2 = p2_q.rd;
  assign bus.WriteData2     = p2_q.data;
  assign bus.Count          = count_q;
  assign bus.Empty          = (count_q == '0);
  assign bus.Full           = (count_q == CW'(DEPTH));
  assign bus.CollisionCount = coll_q;
endmodule
